// File: rtl/fir_mac_pkg.sv
// fir_mac_pkg: shared types and constant helpers for the FIR MAC slice.
// Saturation bounds are sized by width so adders and output stage agree.
package fir_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int MAXW = 128;

  function automatic logic signed [MAXW-1:0] sat_max(input int w);
    return (MAXW'(1) << (w - 1)) - MAXW'(1);
  endfunction

  function automatic logic signed [MAXW-1:0] sat_min(input int w);
    return -(MAXW'(1) << (w - 1));
  endfunction

  function automatic int tap_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_sat_add.sv
// fir_sat_add: combinational signed adder clamping to the W-bit range.
// ovf_o marks that the clamp was applied.
module fir_sat_add
  import fir_mac_pkg::*;
#(
  parameter int W = 40
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MAXV = W'(sat_max(W));
  localparam logic [W-1:0] MINV = W'(sat_min(W));

  logic [W:0] wide;

  // one extra bit of headroom; top two bits disagree on overflow
  always_comb begin
    wide  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    ovf_o = wide[W] ^ wide[W-1];
    sum_o = wide[W-1:0];
    if (ovf_o) sum_o = wide[W] ? MINV : MAXV;
  end

endmodule

// File: rtl/fir_sat_mac_seq.sv
// fir_sat_mac_seq: time-multiplexed FIR, one MAC per cycle, saturating.
// Define FIR_ROUND_EN to round half up before the output shift.
module fir_sat_mac_seq
  import fir_mac_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  NTAPS  = 8,
  parameter int  ACC_W  = 40,
  parameter int  OUT_W  = 16,
  parameter int  SHIFT  = 15,
  localparam int AW     = tap_w(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              sat_flag
);

  typedef logic [AW-1:0] tap_t;

  localparam tap_t LAST = tap_t'(NTAPS - 1);
  localparam logic signed [ACC_W-1:0] OMAX = ACC_W'(sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] OMIN = ACC_W'(sat_min(OUT_W));
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W-1:0] RND = (SHIFT > 0) ? (ACC_W'(1) << RSH) : '0;

  state_t state_q, state_d;
  logic [DATA_W-1:0] coef_q [NTAPS];
  logic [DATA_W-1:0] x_q [NTAPS];
  tap_t wptr_q, wptr_d;
  tap_t k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic clip_q, clip_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic sat_q, sat_d;

  tap_t ridx;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] rnd_sum;
  logic acc_ovf, rnd_ovf, out_clip;
  logic signed [ACC_W-1:0] shv;
  logic [OUT_W-1:0] sat_out;

  // circular read of x[n-k] and the exact product for this tap
  always_comb begin
    if (k_q > wptr_q) ridx = tap_t'(32'(wptr_q) + NTAPS - 32'(k_q));
    else ridx = wptr_q - k_q;
    prod = (2*DATA_W)'($signed(coef_q[k_q]))
         * (2*DATA_W)'($signed(x_q[ridx]));
    prod_ext = ACC_W'(prod);
  end

  fir_sat_add #(.W(ACC_W)) u_acc (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (acc_sum),
    .ovf_o (acc_ovf)
  );

`ifdef FIR_ROUND_EN
  fir_sat_add #(.W(ACC_W)) u_rnd (
    .a_i   (acc_sum),
    .b_i   (RND),
    .sum_o (rnd_sum),
    .ovf_o (rnd_ovf)
  );
`else
  assign rnd_sum = acc_sum;
  assign rnd_ovf = 1'b0;
`endif

  // shift the final sum and clamp it into the output width
  always_comb begin
    shv      = $signed(rnd_sum) >>> SHIFT;
    out_clip = 1'b0;
    sat_out  = OUT_W'(shv);
    if (shv > OMAX) begin
      sat_out  = OUT_W'(OMAX);
      out_clip = 1'b1;
    end else if (shv < OMIN) begin
      sat_out  = OUT_W'(OMIN);
      out_clip = 1'b1;
    end
  end

  // sequencing: accept, run NTAPS taps, hold the result
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    k_d     = k_q;
    acc_d   = acc_q;
    clip_d  = clip_q;
    out_d   = out_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = '0;
          clip_d  = 1'b0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d  = acc_sum;
        clip_d = clip_q | acc_ovf;
        k_d    = k_q + 1'b1;
        if (k_q == LAST) begin
          wptr_d  = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
          out_d   = sat_out;
          sat_d   = clip_q | acc_ovf | rnd_ovf | out_clip;
          k_d     = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // control and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      clip_q  <= 1'b0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      clip_q  <= clip_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  // delay line captures a sample only on an accepted transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
    end else if (state_q == IDLE && in_valid) begin
      x_q[wptr_q] <= in_data;
    end
  end

  // coefficient bank, writable in any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
    end else if (coef_we && (32'(coef_addr) < NTAPS)) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_q;
  assign sat_flag  = sat_q;

endmodule
